// File: rtl/rx_uart_cfg.sv
// rx_uart_cfg: parametrised UART receiver with 3-sample majority voting,
// start-glitch rejection, optional parity, 1 or 2 stop bits and a
// valid/ack hold register with parity, framing and overrun error flags.
module rx_uart_cfg #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BPS       = 4_000_000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 rx_enable_signal,
  input  logic                 rx_ack,
  output logic                 rx_done_signal,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun_err
);

  localparam int DIV = CLK_FREQ / BPS;
  localparam int CW  = $clog2(DIV);

  // Bit-timer landmarks: three majority samples around mid-bit, decision on the last one
  localparam logic [CW-1:0] CNT_S0  = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_S1  = CW'(DIV / 2);
  localparam logic [CW-1:0] CNT_DEC = CW'(DIV / 2 + 1);
  localparam logic [CW-1:0] CNT_END = CW'(DIV - 1);

  localparam logic [3:0] DATA_CNT  = 4'(DATA_BITS);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic       PAR_EN    = (PARITY != 0);
  localparam logic       PAR_ODD   = (PARITY == 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_BREAK  = 3'd6;

  // Line synchronizer (sync2_q is the synchronized line, sync3_q its previous value)
  logic sync1_q, sync2_q, sync3_q;

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bitcnt_q, bitcnt_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 ferr_acc_q, ferr_acc_d;

  logic                 done_q, done_d;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic rs_s, fall_s, maj_s, at_dec_s, at_end_s, load_s, ack_eff_s;

  assign rs_s      = sync2_q;
  assign fall_s    = sync3_q & ~sync2_q;
  assign maj_s     = (s0_q & s1_q) | (s0_q & rs_s) | (s1_q & rs_s);
  assign at_dec_s  = (cnt_q == CNT_DEC);
  assign at_end_s  = (cnt_q == CNT_END);
  assign ack_eff_s = rx_ack & valid_q;

  // Synchronize the asynchronous serial line and keep one delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Receive FSM, bit timer, majority sampling and payload/error accumulation
  always_comb begin
    state_d    = state_q;
    cnt_d      = at_end_s ? {CW{1'b0}} : cnt_q + 1'b1;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    load_s     = 1'b0;
    s0_d       = (cnt_q == CNT_S0) ? rs_s : s0_q;
    s1_d       = (cnt_q == CNT_S1) ? rs_s : s1_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = {CW{1'b0}};
        if (rx_enable_signal && fall_s) begin
          state_d    = ST_START;
          bitcnt_d   = 4'd0;
          perr_acc_d = 1'b0;
          ferr_acc_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        // A start bit that votes high is a glitch: drop it without touching outputs
        if (at_dec_s && maj_s) begin
          state_d = ST_IDLE;
          cnt_d   = {CW{1'b0}};
        end else if (at_end_s) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (at_dec_s) begin
          shift_d  = {maj_s, shift_q[DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q + 4'd1;
        end else if (at_end_s && (bitcnt_q == DATA_CNT)) begin
          bitcnt_d = 4'd0;
          state_d  = PAR_EN ? ST_PARITY : ST_STOP;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (at_dec_s) begin
          perr_acc_d = ((^shift_q) ^ maj_s) != PAR_ODD;
        end else if (at_end_s) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        // Finish at the last stop bit's decision point so the next start edge is not missed
        if (at_dec_s) begin
          ferr_acc_d = ferr_acc_q | ~maj_s;
          if (bitcnt_q == STOP_LAST) begin
            state_d = ST_DONE;
            load_s  = 1'b1;
          end else begin
            state_d = ST_STOP;
          end
        end else if (at_end_s) begin
          bitcnt_d = bitcnt_q + 4'd1;
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_DONE: begin
        cnt_d   = {CW{1'b0}};
        state_d = rs_s ? ST_IDLE : ST_BREAK;
      end
      ST_BREAK: begin
        cnt_d   = {CW{1'b0}};
        state_d = rs_s ? ST_IDLE : ST_BREAK;
      end
      default: begin
        cnt_d   = {CW{1'b0}};
        state_d = ST_IDLE;
      end
    endcase

    // Disarming aborts any frame in flight; nothing is reported for it
    if (!rx_enable_signal) begin
      state_d = ST_IDLE;
      cnt_d   = {CW{1'b0}};
      load_s  = 1'b0;
    end else begin
      load_s  = load_s;
    end
  end

  // Hold register and handshake: load on frame completion, clear on ack of valid data
  always_comb begin
    done_d = load_s;
    if (load_s) begin
      valid_d = 1'b1;
      data_d  = shift_q;
      perr_d  = perr_acc_q;
      ferr_d  = ferr_acc_q | ~maj_s;
    end else begin
      valid_d = ack_eff_s ? 1'b0 : valid_q;
      data_d  = data_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
    end
    // An ack landing with the new frame consumes the old one, so no overrun
    if (load_s && valid_q && !rx_ack) begin
      ovr_d = 1'b1;
    end else if (ack_eff_s) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Register FSM state and datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CW{1'b0}};
      bitcnt_q   <= 4'd0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      shift_q    <= {DATA_BITS{1'b0}};
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitcnt_q   <= bitcnt_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      shift_q    <= shift_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
    end
  end

  // Register all consumer-facing outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= {DATA_BITS{1'b0}};
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      done_q  <= done_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_done_signal = done_q;
  assign rx_valid       = valid_q;
  assign rx_data        = data_q;
  assign rx_parity_err  = perr_q;
  assign rx_frame_err   = ferr_q;
  assign rx_overrun_err = ovr_q;

endmodule

// File: tb/tb_rx_uart_cfg.sv
// Bench for rx_uart_cfg: one 8N1 instance and one 8E2 instance, directed
// scenarios plus random frames checked against a frame-level reference model.
module tb_rx_uart_cfg;
  localparam int DIV = 25;

  logic clk = 1'b0;
  logic rst, rx0, rx1, en, ack;
  logic done0, valid0, perr0, ferr0, ovr0;
  logic done1, valid1, perr1, ferr1, ovr1;
  logic [7:0] data0, data1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dcnt0 = 0, dcnt1 = 0, dcyc0 = 0, dcyc1 = 0;
  logic [7:0] dq0[$];

  rx_uart_cfg u_dut (
    .clk(clk), .rst(rst), .rx_in(rx0), .rx_enable_signal(en), .rx_ack(ack),
    .rx_done_signal(done0), .rx_valid(valid0), .rx_data(data0),
    .rx_parity_err(perr0), .rx_frame_err(ferr0), .rx_overrun_err(ovr0)
  );

  rx_uart_cfg #(.PARITY(2), .STOP_BITS(2)) u_par (
    .clk(clk), .rst(rst), .rx_in(rx1), .rx_enable_signal(en), .rx_ack(ack),
    .rx_done_signal(done1), .rx_valid(valid1), .rx_data(data1),
    .rx_parity_err(perr1), .rx_frame_err(ferr1), .rx_overrun_err(ovr1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record done pulses away from the active edge
  always @(negedge clk) begin
    if (done0) begin
      dcnt0++;
      dcyc0 = cyc;
      dq0.push_back(data0);
    end
    if (done1) begin
      dcnt1++;
      dcyc1 = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: edges from the first clock that samples the low start bit to the done pulse
  function automatic int latency(input int nb, input int p, input int sb);
    return 2 + (1 + nb + p + sb - 1) * DIV + DIV / 2 + 2;
  endfunction

  function automatic logic good_pbit(input logic [7:0] d, input int mode);
    int ones;
    ones = $countones(d);
    return (mode == 2) ? logic'(ones % 2) : logic'(1 - ones % 2);
  endfunction

  function automatic logic exp_perr(input logic [7:0] d, input logic pb, input int mode);
    int ones;
    ones = $countones(d) + int'(pb);
    return (mode == 1) ? ((ones % 2) != 1) : ((ones % 2) != 0);
  endfunction

  // Serialise one frame onto a line; caller sits just after a rising edge
  task automatic send(input int line, input logic [7:0] d, input int pmode, input logic pb,
                      input int sb, input logic stopv, output int cf);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pmode != 0) bits.push_back(pb);
    for (int i = 0; i < sb; i++) bits.push_back(stopv);
    cf = cyc;
    foreach (bits[i]) begin
      if (line == 0) rx0 = bits[i]; else rx1 = bits[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
  endtask

  task automatic wait_cnt0(input string tag, input int target);
    for (int i = 0; i < 4 * DIV && dcnt0 < target; i++) begin
      @(posedge clk);
      #1;
    end
    check(tag, dcnt0, target);
  endtask

  // 8N1 frame on instance 0 with full result check, then ack
  task automatic frame0(input string tag, input logic [7:0] d);
    int cf, p;
    p = dcnt0;
    send(0, d, 0, 1'b0, 1, 1'b1, cf);
    wait_cnt0({tag, "_done"}, p + 1);
    check({tag, "_lat"}, dcyc0, cf + 1 + latency(8, 0, 1));
    check({tag, "_data"}, data0, d);
    check({tag, "_valid"}, valid0, 1'b1);
    check({tag, "_ferr"}, ferr0, 1'b0);
    check({tag, "_perr"}, perr0, 1'b0);
  endtask

  initial begin
    int cf, cfx, p, qs;
    logic [7:0] d;
    logic pb;

    rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; en = 1'b1; ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", done0, 1'b0);
    check("rst_valid", valid0, 1'b0);
    check("rst_data", data0, 8'h00);
    check("rst_errs", {perr0, ferr0, ovr0}, 3'b000);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // 1. Ideal 0xA5 frame, exact latency
    frame0("t1", 8'hA5);
    check("t1_ovr", ovr0, 1'b0);
    pulse_ack();
    check("t1_ack_valid", valid0, 1'b0);

    // Random 8N1 frames
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom_range(0, 255));
      frame0("rnd", d);
      pulse_ack();
      check("rnd_ack_valid", valid0, 1'b0);
    end

    // 2. Short low glitch: rejected by the start-bit vote
    p = dcnt0;
    rx0 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rx0 = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    check("t2_nodone", dcnt0, p);
    check("t2_valid", valid0, 1'b0);

    // 3. Even parity, two stop bits: 0x3C with wrong then right parity, then random frames
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin d = 8'h3C; pb = 1'b1; end
      else if (i == 1) begin d = 8'h3C; pb = 1'b0; end
      else begin d = 8'($urandom_range(0, 255)); pb = 1'($urandom_range(0, 1)); end
      p = dcnt1;
      send(1, d, 2, pb, 2, 1'b1, cf);
      check("t3_done", dcnt1, p + 1);
      check("t3_lat", dcyc1, cf + 1 + latency(8, 1, 2));
      check("t3_data", data1, d);
      check("t3_perr", perr1, exp_perr(d, pb, 2));
      check("t3_perr_good", exp_perr(d, good_pbit(d, 2), 2), 1'b0);
      check("t3_ferr", ferr1, 1'b0);
      pulse_ack();
    end

    // 4. Bad stop bit with line held low, then a clean frame
    p = dcnt0;
    send(0, 8'h55, 0, 1'b0, 1, 1'b0, cf);
    repeat (100) @(posedge clk);
    #1;
    check("t4_done_once", dcnt0, p + 1);
    check("t4_ferr", ferr0, 1'b1);
    check("t4_data", data0, 8'h55);
    rx0 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    pulse_ack();
    frame0("t4b", 8'h12);
    pulse_ack();

    // 5. Back-to-back frames without ack: overrun, then ack clears
    p = dcnt0;
    qs = dq0.size();
    send(0, 8'h01, 0, 1'b0, 1, 1'b1, cf);
    send(0, 8'h02, 0, 1'b0, 1, 1'b1, cf);
    wait_cnt0("t5_done", p + 2);
    check("t5_first", (dq0.size() > qs) ? dq0[qs] : 8'hXX, 8'h01);
    check("t5_data", data0, 8'h02);
    check("t5_valid", valid0, 1'b1);
    check("t5_ovr", ovr0, 1'b1);
    pulse_ack();
    check("t5_ack_valid", valid0, 1'b0);
    check("t5_ack_ovr", ovr0, 1'b0);

    // 5b. Ack coinciding with the load edge: new data, still valid, no overrun
    frame0("t5b_pre", 8'h44);
    cfx = cyc;
    fork
      send(0, 8'h99, 0, 1'b0, 1, 1'b1, cf);
      begin
        repeat (latency(8, 0, 1)) @(posedge clk);
        #1;
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
      end
    join
    check("t5b_cf", cf, cfx);
    check("t5b_data", data0, 8'h99);
    check("t5b_valid", valid0, 1'b1);
    check("t5b_ovr", ovr0, 1'b0);

    // 6. Reset in the middle of a 0xFF frame while outputs are non-zero
    rx0 = 1'b0;
    repeat (DIV) @(posedge clk);
    #1;
    rx0 = 1'b1;
    repeat (3 * DIV + 10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_valid", valid0, 1'b0);
    check("t6_data", data0, 8'h00);
    check("t6_flags", {done0, perr0, ferr0, ovr0}, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5 * DIV) @(posedge clk);
    #1;
    frame0("t6b", 8'h81);

    // 7. Disarm during data bit 3: no done, held outputs untouched, then re-arm
    p = dcnt0;
    fork
      send(0, 8'hC3, 0, 1'b0, 1, 1'b1, cf);
      begin
        repeat (4 * DIV + 10) @(posedge clk);
        #1;
        en = 1'b0;
      end
    join
    repeat (50) @(posedge clk);
    #1;
    check("t7_nodone", dcnt0, p);
    check("t7_held_data", data0, 8'h81);
    check("t7_held_valid", valid0, 1'b1);
    en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    pulse_ack();
    frame0("t7b", 8'h7E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
